// File: rtl/palette_pkg.sv
// Shared types, default palette contents and helpers for palette_arbiter.
// The fade helper is used only when PALETTE_FADE_EN is defined.
package palette_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam int PAL_DEPTH = 16;

  // Entry 0 is the yellow key colour, entry 1 black, the rest light grey.
  localparam logic [11:0] DEFAULT_PAL [PAL_DEPTH] = '{
    12'hFF0, 12'h000, 12'hDDD, 12'hDDD,
    12'hDDD, 12'hDDD, 12'hDDD, 12'hDDD,
    12'hDDD, 12'hDDD, 12'hDDD, 12'hDDD,
    12'hDDD, 12'hDDD, 12'hDDD, 12'hDDD
  };

  typedef enum logic {
    IDLE,
    RELOAD
  } state_t;

  // Scale one channel by (lvl + 1) / 16; lvl 15 is identity.
  function automatic logic [3:0] fade_chan(input logic [3:0] c, input logic [3:0] lvl);
    return 4'((({4'b0, c}) * ({4'b0, lvl} + 8'd1)) >> 4);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans upward from ptr+1 (wrapping) and returns a
// one-hot grant, the encoded winner and whether anyone won.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   grant_id,
  output logic             found
);

  always_comb begin
    logic [IDW-1:0] idx;
    // NOTE: every output gets a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = IDW'((int'(ptr) + i) % N_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/palette_arbiter.sv
// Shared 16-entry RGB palette with round-robin lookup, runtime writes and a
// 16-cycle default reload. Optional output fade: define PALETTE_FADE_EN.
module palette_arbiter
  import palette_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int KEY_INDEX = 0,
  localparam int IDW       = $clog2(N_REQ)
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ-1:0][3:0] req_index,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [3:0]            rsp_red,
  output logic [3:0]            rsp_green,
  output logic [3:0]            rsp_blue,
  output logic                  rsp_transparent,
  input  logic                  cfg_we,
  input  logic [3:0]            cfg_addr,
  input  logic [11:0]           cfg_data,
  input  logic                  cfg_reload,
`ifdef PALETTE_FADE_EN
  input  logic [3:0]            fade_level,
`endif
  output logic                  busy
);

  state_t         state, next_state;
  logic [3:0]     cnt, next_cnt;
  logic [IDW-1:0] rr;
  rgb12_t         pal [PAL_DEPTH];

  logic [N_REQ-1:0] arb_grant;
  logic [IDW-1:0]   arb_id;
  logic             arb_found;
  logic             grant_en, grant_any, cfg_wr, reload_wr;
  logic [3:0]       sel_index;
  rgb12_t           look, shown;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req      (req_valid),
    .ptr      (rr),
    .grant    (arb_grant),
    .grant_id (arb_id),
    .found    (arb_found)
  );

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    grant_en   = 1'b0;
    cfg_wr     = 1'b0;
    reload_wr  = 1'b0;
    busy       = 1'b0;
    unique case (state)
      IDLE: begin
        if (cfg_reload) begin
          next_state = RELOAD;
          next_cnt   = '0;
        end else if (cfg_we) begin
          cfg_wr = 1'b1;
        end else begin
          grant_en = 1'b1;
        end
      end
      RELOAD: begin
        busy      = 1'b1;
        reload_wr = 1'b1;
        next_cnt  = cnt + 4'd1;
        if (cnt == 4'd15) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign req_ready = grant_en ? arb_grant : '0;
  assign grant_any = grant_en & arb_found;
  assign sel_index = req_index[arb_id];
  assign look      = pal[sel_index];

`ifdef PALETTE_FADE_EN
  assign shown = '{r: fade_chan(look.r, fade_level),
                   g: fade_chan(look.g, fade_level),
                   b: fade_chan(look.b, fade_level)};
`else
  assign shown = look;
`endif

  // NOTE: the palette is a small register file that must come out of reset
  // holding the defaults, so unlike a RAM every entry is reset here.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < PAL_DEPTH; i++) pal[i] <= rgb12_t'(DEFAULT_PAL[i]);
    end else if (reload_wr) begin
      pal[cnt] <= rgb12_t'(DEFAULT_PAL[cnt]);
    end else if (cfg_wr) begin
      pal[cfg_addr] <= rgb12_t'(cfg_data);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state           <= IDLE;
      cnt             <= '0;
      rr              <= IDW'(N_REQ - 1);
      rsp_valid       <= 1'b0;
      rsp_id          <= '0;
      rsp_red         <= '0;
      rsp_green       <= '0;
      rsp_blue        <= '0;
      rsp_transparent <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= next_cnt;
      rsp_valid <= grant_any;
      if (grant_any) begin
        rr              <= arb_id;
        rsp_id          <= arb_id;
        rsp_red         <= shown.r;
        rsp_green       <= shown.g;
        rsp_blue        <= shown.b;
        rsp_transparent <= (sel_index == 4'(KEY_INDEX));
      end
    end
  end

endmodule

// File: doc/palette_arbiter.md
Name: palette_arbiter

Overview:
Shared 16-entry, 12-bit RGB palette serving up to N_REQ sprite pipelines (fireboy, watergirl, goat, tiles).
- One lookup per clock, granted round-robin; registered RGB response tagged with the requester ID.
- Owns the palette contents: runtime single-entry writes, plus a sequenced 16-cycle reload of the default palette.
- Sits between sprite ROM index outputs and the VGA color mapper.

Parameters:
- N_REQ, 4, number of lookup requesters (2..8).
- KEY_INDEX, 0, palette index reported as transparent.

Ports:
- Clk  in  1  system clock; all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  lookup request per requester.
- req_index  in  N_REQ x 4  palette index per requester.
- req_ready  out  N_REQ  one-hot grant this cycle; at most one bit set.
- rsp_valid  out  1  response valid.
- rsp_id  out  $clog2(N_REQ)  requester that owns the response.
- rsp_red, rsp_green, rsp_blue  out  4 each  looked-up color.
- rsp_transparent  out  1  looked-up index equals KEY_INDEX.
- cfg_we  in  1  single-entry palette write strobe.
- cfg_addr  in  4  write address.
- cfg_data  in  12  write data, {R,G,B}.
- cfg_reload  in  1  pulse: restore default palette.
- busy  out  1  high while reload is in progress.

Behaviour:
Reset (Reset_n low, asynchronous):
- Palette regs = defaults: entry 0 = 12'hFF0, entry 1 = 12'h000, entries 2..15 = 12'hDDD.
- rsp_valid = 0; rsp_id, rsp_red, rsp_green, rsp_blue, rsp_transparent = 0.
- req_ready = 0; busy = 0; rr pointer = N_REQ-1, so requester 0 wins first; FSM = IDLE.

FSM IDLE:
- cfg_reload takes priority over cfg_we and lookups. It moves to RELOAD with counter = 0 and grants nothing that cycle.
- Else if cfg_we: write the palette entry; req_ready = 0; no grant; rr pointer unchanged.
- Else arbitrate:
  - Scan from rr+1 upward, wrapping modulo N_REQ. The first requester with req_valid set gets req_ready.
  - Set rr to the granted requester.
  - req_ready is combinational from req_valid, state and cfg inputs.

FSM RELOAD:
- busy = 1; req_ready = 0.
- Each cycle, write the default value into entry [counter], then increment the counter.
- After the cycle that writes entry 15, return to IDLE. Reload takes exactly 16 cycles.
- cfg_we and cfg_reload are ignored during RELOAD.

Response timing:
- A grant in cycle T gives rsp_valid = 1 in T+1, with rsp_id, color and rsp_transparent registered from the palette contents at T.
- A cfg_we at T is visible to a lookup granted at T+1.
- rsp_valid deasserts the cycle after a cycle with no grant. There is no backpressure on the response.

Other rules:
- A requester must hold req_valid and req_index until it sees req_ready. Dropping req_valid without a grant is legal; nothing is recorded.
- rsp_transparent is decided by the index, not the color value.
- Reset_n asserted mid-reload aborts the reload and restores all defaults.

Optional Feature:
PALETTE_FADE_EN:
- Defined: adds input fade_level[3:0]. Each output channel = (c * (fade_level + 1)) >> 4, computed before the response register. fade_level 15 gives identity; 0 gives c>>4 = 0. Latency is unchanged and rsp_transparent is unaffected.
- Undefined: the port is absent and colors pass through unscaled.

Decomposition:
Package palette_pkg holds:
- rgb12_t, a packed struct {r, g, b} of 4 bits each.
- PAL_DEPTH = 16.
- The localparam default palette array.
- The FSM state enum {IDLE, RELOAD}.

One sub-module, rr_arbiter, takes req/pointer and returns a one-hot grant plus encoded ID. It is parameterised by N_REQ and is reusable for the tile fetch path.

Test Plan:
1. Release reset, req_valid = 4'b0001, req_index[0] = 1 → req_ready = 0001 in the same cycle; next cycle rsp_valid = 1, rsp_id = 0, RGB = 0/0/0, rsp_transparent = 0.
2. All four request continuously → grants cycle 0,1,2,3,0; responses follow one cycle later with matching rsp_id.
3. Request index 0 → RGB = F/F/0 and rsp_transparent = 1. Request index 9 → D/D/D and transparent = 0.
4. cfg_we addr = 5 data = 12'h3A7 while requester 2 is valid with index 5 → no grant that cycle. Grant the next cycle; response is 3/A/7. rr pointer is not advanced by the write cycle.
5. Write entry 2 = 12'h123, then pulse cfg_reload:
   - busy is high for exactly 16 cycles and req_ready stays 0 throughout.
   - After reload, a lookup of index 2 returns D/D/D.
   - Repeat with Reset_n pulsed at reload cycle 7 → busy = 0 immediately and all defaults are restored.
6. With PALETTE_FADE_EN, fade_level = 7, index 9 → each channel = (13*8)>>4 = 6. With fade_level = 15 → 13 (D).
